// File: rtl/bus_pkg.sv
// Shared definitions for the wait-state bus slave.
//   ADDR_W / DATA_W : bus address and data widths
//   MAX_WAIT        : largest supported wait-state count
//   bus_state_e     : slave state machine encoding
//   in_window()     : inclusive range test that is safe when lo == 0
package bus_pkg;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_WAIT = 7;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StWait,
    StAccess,
    StDone
  } bus_state_e;

  // Offset-based compare: one unsigned subtract plus one compare, and no
  // constant-true "addr >= 0" when the window starts at zero.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] span;
    off  = addr - lo;
    span = hi - lo;
    return off <= span;
  endfunction

endpackage

// File: rtl/bus_byte_ram.sv
// Byte-wide storage for the bus slave: synchronous write, asynchronous read,
// one shared address. Contents are not reset.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   addr  : byte index for both read and write
//   wdata : write data
//   rdata : combinational read data at addr
module bus_byte_ram
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_slave_ws.sv
// Memory or I/O slave on a multiplexed ALE/RD/WR bus with programmable wait
// states. The address is captured on any ALE edge; a hit then waits for one
// strobe, holds READY low for WAIT_STATES cycles and performs the access.
//   CLK     : clock, rising edge
//   RESET_N : asynchronous active-low reset
//   ALE     : address latch enable
//   IOM     : 1 = I/O cycle, 0 = memory cycle
//   RD, WR  : active-low read / write strobes
//   ADDR    : bus address
//   DATA    : bidirectional data, driven only during a selected read
//   READY   : active-high ready, low only while inserting wait states
module bus_slave_ws
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LO_ADDR     = 20'h00000,
  parameter logic [ADDR_W-1:0] HI_ADDR     = 20'h7FFFF,
  parameter bit                IS_IO       = 1'b0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              READY
);

  localparam int unsigned DEPTH = 32'(HI_ADDR - LO_ADDR) + 32'd1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Out-of-range settings saturate at the counter's capacity.
  localparam logic [CNT_W-1:0] WS_LOAD =
      CNT_W'((WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES);

  bus_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              sel_q;
  logic              rd_op_q;
  logic              first_q;
  logic              ready_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] cmp_addr;
  logic              hit;
  logic              one_strobe;
  logic              both_low;
  logic              both_high;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic              drive;
  logic [DATA_W-1:0] rdata;

  // I/O space decodes only the low 16 address bits.
  assign cmp_addr   = IS_IO ? {4'h0, ADDR[15:0]} : ADDR;
  assign hit        = (IOM == IS_IO) && in_window(cmp_addr, LO_ADDR, HI_ADDR);
  assign one_strobe = RD ^ WR;
  assign both_low   = !RD && !WR;
  assign both_high  = RD && WR;
  assign idx        = IDX_W'(addr_q - LO_ADDR);

  // A new ALE on the first ACCESS cycle aborts the write.
  assign mem_we = (state_q == StAccess) && first_q && !rd_op_q && !ALE;
  assign drive  = (state_q == StAccess) && rd_op_q && !RD;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      rd_op_q <= 1'b0;
      first_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else if (ALE) begin
      // ALE wins in every state, which also aborts a cycle in WAIT/ACCESS.
      state_q <= StDecode;
      addr_q  <= cmp_addr;
      sel_q   <= hit;
      first_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDecode: begin
          if (!sel_q) begin
            state_q <= StIdle;
          end else if (both_low) begin
            // Bus error: no access, just wait for both strobes to clear.
            state_q <= StDone;
          end else if (one_strobe) begin
            rd_op_q <= !RD;
            if (WS_LOAD == '0) begin
              state_q <= StAccess;
              first_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= WS_LOAD;
              ready_q <= 1'b0;
            end
          end
        end
        StWait: begin
          // Leaving as the count hits zero yields exactly WS_LOAD low cycles.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StAccess;
            first_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        StAccess: begin
          first_q <= 1'b0;
          if (both_high) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (both_high) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  bus_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (idx),
    .wdata (DATA),
    .rdata (rdata)
  );

  assign DATA  = drive ? rdata : {DATA_W{1'bz}};
  assign READY = ready_q;

endmodule

// File: doc/bus_slave_ws.md
BUS_SLAVE_WS -- requirements
Module: bus_slave_ws

Interface
REQ-001 SHALL have parameter LO_ADDR, default 20'h00000: lowest decoded address of the region (inclusive).
REQ-002 SHALL have parameter HI_ADDR, default 20'h7FFFF: highest decoded address of the region (inclusive); HI_ADDR >= LO_ADDR.
REQ-003 SHALL have parameter IS_IO, default 0: 0 = memory region (20-bit compare, IOM=0); 1 = I/O region (ADDR[15:0] compare, IOM=1).
REQ-004 SHALL have parameter WAIT_STATES, default 0, legal range 0..7: READY-low cycles inserted per access.
REQ-005 SHALL have port CLK, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port ALE, input, 1 bit: address latch enable from the CPU.
REQ-008 SHALL have port IOM, input, 1 bit: 1 = I/O cycle, 0 = memory cycle.
REQ-009 SHALL have port RD, input, 1 bit: active-low read strobe.
REQ-010 SHALL have port WR, input, 1 bit: active-low write strobe.
REQ-011 SHALL have port ADDR, input, 20 bits: latched bus address.
REQ-012 SHALL have port DATA, inout, 8 bits: shared data bus, high-Z unless this device is driving a read.
REQ-013 SHALL have port READY, output, 1 bit: active-high ready, ANDed externally with the other devices.

Function
REQ-014 SHALL store DEPTH = HI_ADDR-LO_ADDR+1 bytes, indexed by latched address minus LO_ADDR.
REQ-015 SHALL implement states IDLE, DECODE, WAIT, ACCESS and DONE.
REQ-016 SHALL, at a rising CLK edge with ALE=1 in any state, capture ADDR and IOM, compute sel, and enter DECODE.
REQ-017 SHALL set sel=1 only if the captured IOM equals IS_IO and the compared address lies within [LO_ADDR, HI_ADDR].
REQ-018 SHALL, in DECODE with sel=0, return to IDLE and never drive DATA or lower READY.
REQ-019 SHALL, in DECODE with sel=1 and exactly one of RD/WR low, load wait counter = WAIT_STATES and enter WAIT, or enter ACCESS directly if WAIT_STATES=0.
REQ-020 SHALL, in DECODE with sel=1 and RD=WR=1, remain in DECODE.
REQ-021 SHALL hold READY=0 in WAIT, decrement the counter each cycle, and enter ACCESS in the cycle after the counter reaches 0, giving exactly WAIT_STATES READY-low cycles.
REQ-022 SHALL, in ACCESS for a read, drive DATA with mem[index] from the first ACCESS cycle while RD=0.
REQ-023 SHALL, in ACCESS for a write, write DATA into mem[index] exactly once, on the first ACCESS cycle.
REQ-024 SHALL move from ACCESS to DONE, release DATA to high-Z, and return to IDLE once RD=1 and WR=1.
REQ-025 SHALL treat RD=0 and WR=0 together as a bus error: no read, no write, no drive, READY=1; wait in DONE until both strobes are high.
REQ-026 SHALL have ALE=1 during WAIT or ACCESS abort the current cycle, with no write, DATA high-Z next cycle and READY=1 next cycle.
REQ-027 SHALL handle the boundary addresses LO_ADDR and HI_ADDR as hits, and LO_ADDR-1 and HI_ADDR+1 as misses.
REQ-028 SHALL hold READY=1 in every state except WAIT.

Reset
REQ-029 SHALL, on RESET_N=0 at any time (including mid-access), force IDLE, READY=1, DATA high-Z, wait counter 0 and captured address 0.
REQ-030 SHALL leave memory contents unaffected by reset.

Structure
REQ-031 SHALL take ADDR_W=20, DATA_W=8, the state enum type and the MAX_WAIT=7 constant from shared package bus_pkg.
REQ-032 SHALL instantiate storage as sub-module bus_byte_ram (sync write, async read, DEPTH parameter).

Verification
REQ-033 Bench: write 8'hA5 to 20'h00010 with WAIT_STATES=0, then read it back -> DATA=8'hA5 during RD low; READY never 0.
REQ-034 Bench: WAIT_STATES=3, read 20'h7FFFF -> READY low exactly 3 cycles, then DATA valid; DATA high-Z after RD rises.
REQ-035 Bench: IS_IO=1, range 16'h1C00..16'h1DFF, IOM=1 write 8'h3C to 16'h1DFF, read back -> 8'h3C; IOM=1 access to 16'h1E00 -> no drive, READY=1.
REQ-036 Bench: memory-mode device, IOM=1 cycle at an in-range address -> ignored, memory unchanged.
REQ-037 Bench: RD=WR=0 together -> no drive, memory unchanged, READY=1, back to IDLE after release.
REQ-038 Bench: RESET_N low during WAIT (WAIT_STATES=5) -> READY=1 and DATA high-Z immediately; earlier memory data preserved.
